// File: rtl/keypad_pkg.sv
// Shared definitions for the 9-key numeric keypad front-end: key count, debounce FSM states
// and the single-key check.
package keypad_pkg;

    localparam int unsigned KEY_N = 9;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_RELEASE
    } state_t;

    // True when exactly one key line is active.
    function automatic logic is_onehot(input logic [31:0] v);
        return $countones(v) == 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, with a configurable reset value.
module sync_2ff #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            q      <= RST_VAL;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/key_debounce_onehot.sv
// Keypad front-end: synchronise, debounce and chord-reject the active-low key lines.
// Define KEY_REPEAT_EN to add auto-repeat of key_valid while a key stays held.
module key_debounce_onehot #(
    parameter int unsigned KEY_N           = keypad_pkg::KEY_N,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned REPEAT_CYCLES   = 25_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_N-1:0] key_n,
    output logic [KEY_N-1:0] data_out,
    output logic             key_valid,
    output logic             key_held
);

    import keypad_pkg::*;

    if (DEBOUNCE_CYCLES < 2 || 64'(DEBOUNCE_CYCLES) > (64'd1 << CNT_W) || REPEAT_CYCLES < 1)
    begin : g_bad_params
        $error("key_debounce_onehot: illegal parameter values");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [KEY_N-1:0] key_sync;
    logic [KEY_N-1:0] pressed;
    logic             single;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [KEY_N-1:0] cand_q, cand_d;
    logic [KEY_N-1:0] data_d;
    logic             valid_d;
    logic             rep_fire;

    sync_2ff #(
        .WIDTH   (KEY_N),
        .RST_VAL ({KEY_N{1'b1}})
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (key_n),
        .q     (key_sync)
    );

    assign pressed = ~key_sync;
    assign single  = is_onehot(32'(pressed));

`ifdef KEY_REPEAT_EN
    localparam int unsigned REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    logic             held_stay;
    logic [REP_W-1:0] rep_q;

    // Counts only while the key is steadily held; any other cycle restarts the period.
    assign held_stay = (state_q == HELD) && (pressed == cand_q);
    assign rep_fire  = held_stay && (rep_q == REP_W'(REPEAT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q <= '0;
        end else if (!held_stay || rep_fire) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_q + REP_W'(1);
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        data_d  = data_out;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (single) begin
                    cand_d  = pressed;
                    cnt_d   = '0;
                    state_d = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (pressed != cand_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = HELD;
                    data_d  = cand_q;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (pressed != cand_q) begin
                    state_d = DEB_RELEASE;
                    cnt_d   = '0;
                end else begin
                    valid_d = rep_fire;
                end
            end
            DEB_RELEASE: begin
                if (pressed == cand_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (pressed != '0) begin
                    // A foreign key restarts the release window.
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    data_d  = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cand_q    <= '0;
            data_out  <= '0;
            key_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            data_out  <= data_d;
            key_valid <= valid_d;
        end
    end

    assign key_held = (state_q == HELD) || (state_q == DEB_RELEASE);

endmodule

// File: tb/tb_key_debounce_onehot.sv
// Self-checking bench for key_debounce_onehot: directed scenarios plus randomized press episodes
// compared cycle by cycle against a run-length reference model.
module tb_key_debounce_onehot;

    localparam int unsigned D  = 4;
    localparam int unsigned R  = 10;
    localparam int unsigned KN = 9;
`ifdef KEY_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [KN-1:0] key_n = '1;
    logic [KN-1:0] data_out;
    logic          key_valid;
    logic          key_held;

    always #5 clk = ~clk;

    key_debounce_onehot #(
        .KEY_N           (KN),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (4),
        .REPEAT_CYCLES   (R)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_n     (key_n),
        .data_out  (data_out),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: run length of identical raw samples and the accepted key.
    logic [KN-1:0] m_run_val, m_key;
    int            m_run_len, m_held_run;
    bit            m_prev_k;
    // Two-sample pipeline between raw sampling and the debounce decision.
    logic [KN-1:0] pd0, pd1;
    bit            pv0, pv1;

    int edge_no, valid_cnt, first_valid_edge, clear_edge;
    bit prev_nz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run_val  = '0;
        m_key      = '0;
        m_run_len  = 0;
        m_held_run = 0;
        m_prev_k   = 1'b0;
        pd0 = '0; pd1 = '0; pv0 = 1'b0; pv1 = 1'b0;
    endtask

    // Press accepted after D+1 equal single-key samples; release after D+1 zero samples;
    // repeat every R further samples of the held key.
    task automatic model_step(input logic [KN-1:0] r, output logic [KN-1:0] k, output bit v);
        if (r == m_run_val) m_run_len++;
        else begin
            m_run_val = r;
            m_run_len = 1;
        end
        v = 1'b0;
        if (m_key == '0) begin
            if ($countones(r) == 1 && m_run_len == D + 1) begin
                m_key      = r;
                v          = 1'b1;
                m_held_run = 0;
                m_prev_k   = 1'b1;
            end
        end else if (r == m_key) begin
            if (m_prev_k) begin
                m_held_run++;
                if (REP && m_held_run == R) begin
                    v          = 1'b1;
                    m_held_run = 0;
                end
            end else begin
                m_held_run = 0;
            end
            m_prev_k = 1'b1;
        end else begin
            m_prev_k   = 1'b0;
            m_held_run = 0;
            if (r == '0 && m_run_len == D + 1) m_key = '0;
        end
        k = m_key;
    endtask

    task automatic seg_start();
        edge_no          = 0;
        valid_cnt        = 0;
        first_valid_edge = -1;
        clear_edge       = -1;
        prev_nz          = (data_out != '0);
    endtask

    task automatic cycle(input logic [KN-1:0] raw);
        logic [KN-1:0] k, exp_d;
        bit            v, exp_v;
        key_n = ~raw;
        @(posedge clk);
        #1;
        edge_no++;
        exp_d = pd1;
        exp_v = pv1;
        pd1   = pd0;
        pv1   = pv0;
        model_step(raw, k, v);
        pd0 = k;
        pv0 = v;
        check("data_out", 32'(data_out), 32'(exp_d));
        check("key_valid", 32'(key_valid), 32'(exp_v));
        check("key_held", 32'(key_held), 32'(exp_d != '0));
        if (key_valid) begin
            valid_cnt++;
            if (first_valid_edge < 0) first_valid_edge = edge_no;
        end
        if (prev_nz && data_out == '0 && clear_edge < 0) clear_edge = edge_no;
        prev_nz = (data_out != '0);
    endtask

    task automatic hold(input logic [KN-1:0] raw, input int n);
        repeat (n) cycle(raw);
    endtask

    task automatic episode();
        logic [KN-1:0] v, b;
        int            a, c, nb;
        if ($urandom_range(0, 4) == 0) begin
            a = int'($urandom_range(0, KN - 1));
            c = (a + 1 + int'($urandom_range(0, KN - 2))) % KN;
            v = '0;
            v[a] = 1'b1;
            v[c] = 1'b1;
        end else begin
            b = 9'd1;
            v = b << $urandom_range(0, KN - 1);
        end
        nb = int'($urandom_range(0, 3));
        repeat (nb) begin
            hold(v, int'($urandom_range(1, 3)));
            hold('0, int'($urandom_range(1, 2)));
        end
        hold(v, int'($urandom_range(1, 16)));
        nb = int'($urandom_range(0, 3));
        repeat (nb) begin
            hold('0, int'($urandom_range(1, 2)));
            hold(v, int'($urandom_range(1, 3)));
        end
        hold('0, int'($urandom_range(D + 4, D + 8)));
    endtask

    initial begin
        model_reset();
        // Reset with idle lines.
        rst_n = 1'b0;
        key_n = '1;
        repeat (2) @(posedge clk);
        #1;
        check("reset data_out", 32'(data_out), 32'h0);
        check("reset key_valid", 32'(key_valid), 32'h0);
        check("reset key_held", 32'(key_held), 32'h0);
        rst_n = 1'b1;
        hold('0, 3);

        // Single press of key 4, held 20 cycles.
        seg_start();
        hold(9'h008, 20);
        check("press first valid edge", 32'(first_valid_edge), 32'd7);
        check("press valid count", 32'(valid_cnt), REP ? 32'd2 : 32'd1);
        check("press data_out", 32'(data_out), 32'h008);
        check("press key_held", 32'(key_held), 32'h1);
        hold('0, 10);

        // Reset while held clears outputs without a clock edge.
        hold(9'h008, 12);
        rst_n = 1'b0;
        #1;
        check("async reset data_out", 32'(data_out), 32'h0);
        check("async reset key_valid", 32'(key_valid), 32'h0);
        check("async reset key_held", 32'(key_held), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        seg_start();
        hold(9'h008, 10);
        check("post-reset valid edge", 32'(first_valid_edge), 32'd7);
        hold('0, 10);

        // Bounce on key 1 before settling.
        seg_start();
        hold(9'h001, 2);
        hold('0, 1);
        hold(9'h001, 12);
        check("bounce valid count", 32'(valid_cnt), 32'd1);
        check("bounce valid edge", 32'(first_valid_edge), 32'd10);
        check("bounce data_out", 32'(data_out), 32'h001);
        hold('0, 10);

        // Two-key chord is ignored.
        seg_start();
        hold(9'h006, 20);
        check("chord valid count", 32'(valid_cnt), 32'd0);
        check("chord data_out", 32'(data_out), 32'h0);
        check("chord key_held", 32'(key_held), 32'h0);
        hold('0, 5);

        // Short release bounce while held, then a clean release.
        seg_start();
        hold(9'h010, 10);
        hold('0, 2);
        hold(9'h010, 6);
        check("rebounce valid count", 32'(valid_cnt), 32'd1);
        check("rebounce data_out", 32'(data_out), 32'h010);
        seg_start();
        hold('0, 12);
        check("release clear edge", 32'(clear_edge), 32'd7);
        check("release key_held", 32'(key_held), 32'h0);

        // Long hold exercises auto-repeat when enabled.
        seg_start();
        hold(9'h100, 40);
        check("long hold valid count", 32'(valid_cnt), REP ? 32'd4 : 32'd1);
        check("long hold first valid", 32'(first_valid_edge), 32'd7);
        hold('0, 12);

        // Randomized press episodes with bounce, short presses and chords.
        repeat (40) episode();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
